// File: rtl/fpcvt_pkg.sv
// Shared widths, FSM state encoding and converter result payload for the
// fpcvt scheduler slice.
package fpcvt_pkg;

    localparam int unsigned D_W   = 12;
    localparam int unsigned E_W   = 3;
    localparam int unsigned F_W   = 4;
    localparam int unsigned CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        HOLD = 2'd2
    } state_t;

    typedef struct packed {
        logic           s;
        logic [E_W-1:0] e;
        logic [F_W-1:0] f;
    } result_t;

endpackage

// File: rtl/fpcvt.sv
// Combinational 12-bit two's-complement to sign/3-bit exponent/4-bit
// significand converter with round-half-up on the fifth bit and saturation.
module fpcvt
    import fpcvt_pkg::*;
(
    input  logic [D_W-1:0] i_d,
    output result_t        o_res
);

    logic [D_W-1:0] w_mag;
    logic [3:0]     w_lz;
    logic [E_W:0]   w_e;
    logic [F_W:0]   w_sh;
    logic [F_W:0]   w_f;

    always_comb begin
        w_mag = i_d[D_W-1] ? (~i_d + D_W'(1)) : i_d;
        w_lz  = 4'(D_W);
        for (int i = 0; i < int'(D_W); i++) begin
            if (w_mag[i]) w_lz = 4'(int'(D_W) - 1 - i);
        end

        w_e  = '0;
        w_sh = '0;
        w_f  = {1'b0, w_mag[F_W-1:0]};
        // Shift one past the significand so the LSB of w_sh is the round bit.
        if (w_lz < 4'd8) begin
            w_e  = 4'd8 - w_lz;
            w_sh = 5'(w_mag >> (w_e - 4'd1));
            w_f  = {1'b0, w_sh[F_W:1]} + {4'b0, w_sh[0]};
            if (w_f[F_W]) begin
                w_f = 5'b01000;
                w_e = w_e + 4'd1;
            end
        end

        o_res.s = i_d[D_W-1];
        if (w_e > 4'd7) begin
            o_res.e = 3'd7;
            o_res.f = 4'hF;
        end else begin
            o_res.e = w_e[E_W-1:0];
            o_res.f = w_f[F_W-1:0];
        end
    end

endmodule

// File: rtl/fpcvt_sched.sv
// Round-robin front end sharing one fpcvt converter among NREQ requesters,
// with a registered result on a valid/ready output port.
module fpcvt_sched
    import fpcvt_pkg::*;
#(
    parameter int unsigned NREQ = 2,
    parameter int unsigned IDW  = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [D_W*NREQ-1:0]   req_d,
    output logic [NREQ-1:0]       req_ready,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [IDW-1:0]        out_id,
    output logic                  out_s,
    output logic [E_W-1:0]        out_e,
    output logic [F_W-1:0]        out_f,
    output logic [CNT_W-1:0]      conv_count
);

    localparam int unsigned SW = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [IDW-1:0]   r_last;
    logic [D_W-1:0]   r_d;
    logic [IDW-1:0]   r_id;
    result_t          r_res;
    logic [IDW-1:0]   r_out_id;
    logic             r_out_valid;
    logic [CNT_W-1:0] r_count;

    logic [IDW:0]     w_pick;
    logic             w_accept;
    logic             w_done;
    logic [D_W-1:0]   w_sel_d;
    result_t          w_res;

    // First valid requester searching upward from last+1; MSB flags a hit.
    function automatic logic [IDW:0] rr_pick(input logic [NREQ-1:0] v,
                                             input logic [IDW-1:0]  last);
        logic [IDW:0] pick;
        int           idx;
        pick = '0;
        for (int k = int'(NREQ); k > 0; k--) begin
            idx = (int'(last) + k) % int'(NREQ);
            if (v[SW'(idx)]) pick = {1'b1, IDW'(idx)};
        end
        return pick;
    endfunction

    assign w_pick = rr_pick(req_valid, r_last);

    always_comb begin
        w_sel_d = '0;
        for (int j = 0; j < int'(NREQ); j++) begin
            if (w_pick[IDW-1:0] == IDW'(j)) w_sel_d = req_d[j*D_W +: D_W];
        end
    end

    fpcvt u_fpcvt (
        .i_d   (r_d),
        .o_res (w_res)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next state, grant strobe and handshake decode.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_done      = 1'b0;
        req_ready   = '0;
        case (r_state)
            IDLE: if (w_pick[IDW]) begin
                w_accept    = 1'b1;
                w_state_nxt = CONV;
            end
            CONV: w_state_nxt = HOLD;
            HOLD: if (out_ready) begin
                w_done      = 1'b1;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
        for (int j = 0; j < int'(NREQ); j++) begin
            req_ready[j] = w_accept && rst_n && (w_pick[IDW-1:0] == IDW'(j));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last      <= IDW'(NREQ - 1);
            r_d         <= '0;
            r_id        <= '0;
            r_res       <= '0;
            r_out_id    <= '0;
            r_out_valid <= 1'b0;
            r_count     <= '0;
        end else begin
            r_out_valid <= (w_state_nxt == HOLD);
            if (w_accept) begin
                r_d    <= w_sel_d;
                r_id   <= w_pick[IDW-1:0];
                r_last <= w_pick[IDW-1:0];
            end
            if (r_state == CONV) begin
                r_res    <= w_res;
                r_out_id <= r_id;
            end
            if (w_done) r_count <= r_count + CNT_W'(1);
        end
    end

    assign out_valid  = r_out_valid;
    assign out_id     = r_out_id;
    assign out_s      = r_res.s;
    assign out_e      = r_res.e;
    assign out_f      = r_res.f;
    assign conv_count = r_count;

endmodule
